// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: default datapath widths and the
// ALUOp encodings the stage passes through to the ALU.
package id_ex_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1010;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass mux for one source register of the held instruction.
// Ports:
//   i_rs_addr                            source-register index of the held instruction
//   i_held_data                          register-file value captured at issue
//   i_exmem_rd/_reg_write/_result        youngest in-flight producer
//   i_memwb_rd/_reg_write/_result        older in-flight producer
//   o_operand                            value the ALU should see
// The youngest producer wins; x0 is hard-wired zero and never bypassed.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic [REGW-1:0] i_rs_addr,
  input  logic [XLEN-1:0] i_held_data,
  input  logic [REGW-1:0] i_exmem_rd,
  input  logic            i_exmem_reg_write,
  input  logic [XLEN-1:0] i_exmem_result,
  input  logic [REGW-1:0] i_memwb_rd,
  input  logic            i_memwb_reg_write,
  input  logic [XLEN-1:0] i_memwb_result,
  output logic [XLEN-1:0] o_operand
);

  logic w_ex_hit;
  logic w_wb_hit;

  assign w_ex_hit = i_exmem_reg_write && (i_exmem_rd == i_rs_addr) && (i_rs_addr != '0);
  assign w_wb_hit = i_memwb_reg_write && (i_memwb_rd == i_rs_addr) && (i_rs_addr != '0);

  always_comb begin
    o_operand = i_held_data;
    if (w_ex_hit) begin
      o_operand = i_exmem_result;
    end else if (w_wb_hit) begin
      o_operand = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Holds one decoded instruction behind valid/ready handshakes, bypasses
// EX/MEM and MEM/WB results onto the operands, selects the immediate for B
// and stalls decode for one cycle on a load-use dependency.
// Ports:
//   clk, rst_n, flush                    clock, async active-low reset, redirect kill
//   in_valid/in_ready + in_*             decoded instruction from ID
//   exmem_*, memwb_*                     bypass sources
//   out_valid/out_ready                  handshake towards EX/MEM
//   alu_a, alu_b, alu_op                 ALU inputs
//   out_store_data, out_rd,
//   out_reg_write, out_is_load           side-band carried with the instruction
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] in_rs1_addr,
  input  logic [REGW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [3:0]      in_alu_op,
  input  logic [REGW-1:0] in_rd_addr,
  input  logic            in_reg_write,
  input  logic            in_is_load,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] out_store_data,
  output logic [REGW-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_is_load
);

  logic            r_valid;
  logic [REGW-1:0] r_rs1_addr;
  logic [REGW-1:0] r_rs2_addr;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic            r_use_imm;
  logic [3:0]      r_alu_op;
  logic [REGW-1:0] r_rd;
  logic            r_reg_write;
  logic            r_is_load;

  logic            w_hazard;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_stall;
  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  // A held load cannot bypass its data yet; a consumer must wait until the
  // load has moved on and then pick the value up from a bypass port.
  assign w_hazard = r_valid && r_is_load && (r_rd != '0) && in_valid &&
                    ((in_rs1_addr == r_rd) || (!in_use_imm && (in_rs2_addr == r_rd)));

  assign w_in_ready = (!r_valid || out_ready) && !w_hazard;
  assign w_accept   = in_valid && w_in_ready;
  assign w_stall    = r_valid && !out_ready;

  // A MEM/WB producer can retire while we are stalled; capture it so the
  // operand does not fall back to the stale register-file read.
  assign w_wb_hit1 = memwb_reg_write && (memwb_rd == r_rs1_addr) && (r_rs1_addr != '0);
  assign w_wb_hit2 = memwb_reg_write && (memwb_rd == r_rs2_addr) && (r_rs2_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_alu_op    <= ALU_AND;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_is_load   <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_accept && !flush) begin
        r_rs1_addr  <= in_rs1_addr;
        r_rs2_addr  <= in_rs2_addr;
        r_rs1_data  <= in_rs1_data;
        r_rs2_data  <= in_rs2_data;
        r_imm       <= in_imm;
        r_use_imm   <= in_use_imm;
        r_alu_op    <= in_alu_op;
        r_rd        <= in_rd_addr;
        r_reg_write <= in_reg_write;
        r_is_load   <= in_is_load;
      end else if (w_stall) begin
        if (w_wb_hit1) begin
          r_rs1_data <= memwb_result;
        end
        if (w_wb_hit2) begin
          r_rs2_data <= memwb_result;
        end
      end
    end
  end

  id_ex_stage_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .i_rs_addr         (r_rs1_addr),
    .i_held_data       (r_rs1_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_operand         (w_fwd_rs1)
  );

  id_ex_stage_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .i_rs_addr         (r_rs2_addr),
    .i_held_data       (r_rs2_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_operand         (w_fwd_rs2)
  );

  assign in_ready       = w_in_ready;
  assign out_valid      = r_valid;
  assign alu_a          = w_fwd_rs1;
  assign alu_b          = r_use_imm ? r_imm : w_fwd_rs2;
  assign alu_op         = r_alu_op;
  assign out_store_data = w_fwd_rs2;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_reg_write;
  assign out_is_load    = r_is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic [3:0]  in_alu_op;
  logic        in_reg_write, in_is_load;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b, out_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_is_load;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [3:0]  op;
    logic        rw, ld;
  } entry_t;

  entry_t held_q[$];
  logic [3:0] ops [5];

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_is_load(out_is_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_use_imm = 1'b0; in_alu_op = ALU_AND; in_reg_write = 1'b0; in_is_load = 1'b0;
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
    out_ready = 1'b1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic use_imm, input logic [3:0] op, input logic [4:0] rd,
                       input logic rw, input logic ld);
    in_valid = 1'b1;
    in_rs1_addr = rs1; in_rs2_addr = rs2; in_rs1_data = d1; in_rs2_data = d2;
    in_imm = imm; in_use_imm = use_imm; in_alu_op = op; in_rd_addr = rd;
    in_reg_write = rw; in_is_load = ld;
  endtask

  // Reference model: bypass value chosen by producer age
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] held);
    if (rs == 5'd0) return held;
    if (exmem_reg_write && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd == rs) return memwb_result;
    return held;
  endfunction

  function automatic logic model_ready();
    logic dep;
    dep = 1'b0;
    if (held_q.size() != 0 && held_q[0].ld && held_q[0].rd != 5'd0 && in_valid)
      dep = (in_rs1_addr == held_q[0].rd) || (!in_use_imm && in_rs2_addr == held_q[0].rd);
    return (held_q.size() == 0 || out_ready) && !dep;
  endfunction

  task automatic model_check();
    entry_t e;
    chk("rnd_in_ready", 32'(in_ready), 32'(model_ready()));
    chk("rnd_out_valid", 32'(out_valid), 32'(held_q.size()));
    if (held_q.size() != 0) begin
      e = held_q[0];
      chk("rnd_alu_a", alu_a, fwd(e.rs1, e.d1));
      chk("rnd_alu_b", alu_b, e.use_imm ? e.imm : fwd(e.rs2, e.d2));
      chk("rnd_store", out_store_data, fwd(e.rs2, e.d2));
      chk("rnd_alu_op", 32'(alu_op), 32'(e.op));
      chk("rnd_rd", 32'(out_rd), 32'(e.rd));
      chk("rnd_rw", 32'(out_reg_write), 32'(e.rw));
      chk("rnd_ld", 32'(out_is_load), 32'(e.ld));
    end
  endtask

  task automatic model_step();
    entry_t e;
    logic take;
    take = in_valid && model_ready();
    if (flush) begin
      held_q.delete();
    end else if (take) begin
      e.rs1 = in_rs1_addr; e.rs2 = in_rs2_addr; e.rd = in_rd_addr;
      e.d1 = in_rs1_data; e.d2 = in_rs2_data; e.imm = in_imm;
      e.use_imm = in_use_imm; e.op = in_alu_op; e.rw = in_reg_write; e.ld = in_is_load;
      held_q.delete();
      held_q.push_back(e);
    end else if (out_ready) begin
      held_q.delete();
    end else if (held_q.size() != 0) begin
      // a producer retiring from MEM/WB during a stall is remembered
      if (memwb_reg_write && held_q[0].rs1 != 5'd0 && memwb_rd == held_q[0].rs1)
        held_q[0].d1 = memwb_result;
      if (memwb_reg_write && held_q[0].rs2 != 5'd0 && memwb_rd == held_q[0].rs2)
        held_q[0].d2 = memwb_result;
    end
  endtask

  initial begin
    ops[0] = ALU_AND; ops[1] = ALU_OR; ops[2] = ALU_ADD; ops[3] = ALU_SUB; ops[4] = ALU_SRL;
    idle();
    rst_n = 1'b0;

    // 1. reset, and reset asserted while holding
    repeat (2) @(negedge clk);
    #1 chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    offer(5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, ALU_SUB, 5'd3, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("hold_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1 chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(in_ready), 32'd1);

    // 2. plain ADD with immediate
    @(negedge clk);
    idle();
    offer(5'd5, 5'd0, 32'd7, 32'd0, 32'd3, 1'b1, ALU_ADD, 5'd1, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("add_a", alu_a, 32'd7);
    chk("add_b", alu_b, 32'd3);
    chk("add_op", 32'(alu_op), 32'(ALU_ADD));
    chk("add_valid", 32'(out_valid), 32'd1);

    // 3. forwarding priority
    offer(5'd4, 5'd0, 32'd1, 32'd0, 32'd0, 1'b0, ALU_OR, 5'd2, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    exmem_rd = 5'd4; exmem_reg_write = 1'b1; exmem_result = 32'hAA;
    memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'hBB;
    #1 chk("fwd_exmem", alu_a, 32'hAA);
    exmem_reg_write = 1'b0;
    #1 chk("fwd_memwb", alu_a, 32'hBB);
    memwb_reg_write = 1'b0; out_ready = 1'b1;
    offer(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, ALU_AND, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    exmem_rd = 5'd0; exmem_reg_write = 1'b1;
    memwb_rd = 5'd0; memwb_reg_write = 1'b1;
    #1 chk("fwd_x0", alu_a, 32'd0);
    chk("fwd_x0_valid", 32'(out_valid), 32'd1);

    // 4. load-use: one bubble
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; out_ready = 1'b1;
    offer(5'd1, 5'd0, 32'd0, 32'd0, 32'h10, 1'b1, ALU_ADD, 5'd6, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    offer(5'd1, 5'd6, 32'h21, 32'h22, 32'd0, 1'b0, ALU_SUB, 5'd7, 1'b1, 1'b0);
    #1 chk("lu_ready", 32'(in_ready), 32'd0);
    chk("lu_load_held", 32'(out_is_load), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1 chk("lu_bubble", 32'(out_valid), 32'd0);
    chk("lu_ready2", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lu_sub_valid", 32'(out_valid), 32'd1);
    chk("lu_sub_op", 32'(alu_op), 32'(ALU_SUB));
    chk("lu_sub_b", alu_b, 32'h22);

    // 5. refresh during stall
    offer(5'd2, 5'd9, 32'd0, 32'h11, 32'd0, 1'b0, ALU_ADD, 5'd3, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    memwb_rd = 5'd9; memwb_reg_write = 1'b1; memwb_result = 32'h55;
    #1 chk("refr_c1", alu_b, 32'h55);
    @(posedge clk);
    @(negedge clk);
    memwb_reg_write = 1'b0;
    #1 chk("refr_c2", alu_b, 32'h55);
    chk("refr_c2_store", out_store_data, 32'h55);
    @(posedge clk);
    @(negedge clk);
    #1 chk("refr_c3", alu_b, 32'h55);

    // 6. flush with simultaneous accept
    out_ready = 1'b1; flush = 1'b1;
    offer(5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, ALU_OR, 5'd4, 1'b1, 1'b0);
    #1 chk("fl_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("fl_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 chk("fl_nodup", 32'(out_valid), 32'd0);
    offer(5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, ALU_OR, 5'd4, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    #1 chk("fl_bp_valid", 32'(out_valid), 32'd0);

    // randomized phase against the reference model
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    held_q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid        = ($urandom_range(0, 9) < 7);
      in_rs1_addr     = 5'($urandom_range(0, 7));
      in_rs2_addr     = 5'($urandom_range(0, 7));
      in_rd_addr      = 5'($urandom_range(0, 7));
      in_rs1_data     = $urandom;
      in_rs2_data     = $urandom;
      in_imm          = $urandom;
      in_use_imm      = 1'($urandom_range(0, 1));
      in_alu_op       = ops[$urandom_range(0, 4)];
      in_reg_write    = 1'($urandom_range(0, 1));
      in_is_load      = ($urandom_range(0, 2) == 0);
      exmem_rd        = 5'($urandom_range(0, 7));
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_result    = $urandom;
      memwb_rd        = 5'($urandom_range(0, 7));
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_result    = $urandom;
      out_ready       = ($urandom_range(0, 9) < 6);
      flush           = ($urandom_range(0, 19) == 0);
      #1 model_check();
      @(posedge clk);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
